// File: rtl/arb_pkg.sv
// Shared types and requester indices for the three-way SRAM port arbiter.
package arb_pkg;

  localparam int NUM_REQ      = 3;
  localparam int REQ_LOADER   = 0;
  localparam int REQ_WB       = 1;
  localparam int REQ_READBACK = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] oneHot(input logic [1:0] idx);
    oneHot = 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first non-excluded requester after last_owner, wrapping modulo NUM_REQ.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_owner,
  input  logic [NUM_REQ-1:0] exclude,
  output logic               valid,
  output logic [1:0]         winner
);

  logic [NUM_REQ-1:0] w_cand;
  logic [1:0]         w_start;
  logic [2:0]         w_sum;
  logic [1:0]         w_idx;

  assign w_cand = req & ~exclude;

  // Walk the search order backwards so the earliest eligible slot is the last one written.
  always_comb begin
    w_start = (last_owner >= 2'(NUM_REQ - 1)) ? 2'd0 : last_owner + 2'd1;
    valid   = 1'b0;
    winner  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, w_start} + 3'(i);
      if (w_sum >= 3'(NUM_REQ)) w_sum = w_sum - 3'(NUM_REQ);
      w_idx = w_sum[1:0];
      if (w_cand[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among the SPI loader, array writeback and SPI readback,
// with burst limiting so a busy owner yields after MAX_BURST beats when someone else is waiting.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   we,
  input  logic [ADDR_SIZE-1:0] addr      [NUM_REQ],
  input  logic [WORD_SIZE-1:0] wdata     [NUM_REQ],
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rvalid,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t             r_state;
  logic [1:0]         r_owner;
  logic [1:0]         r_last_owner;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [NUM_REQ-1:0] r_rvalid;

  logic                 w_own;
  logic                 w_ownReq;
  logic                 w_ownWe;
  logic [ADDR_SIZE-1:0] w_ownAddr;
  logic [WORD_SIZE-1:0] w_ownWdata;
  logic                 w_beat;
  logic                 w_handover;
  logic [NUM_REQ-1:0]   w_ownOneHot;
  logic [1:0]           w_pickLast;
  logic [NUM_REQ-1:0]   w_pickExclude;
  logic                 w_pickValid;
  logic [1:0]           w_pickWinner;

  // Only the current owner's signals ever reach the SRAM; other requesters are invisible here.
  always_comb begin
    w_ownReq   = req[REQ_LOADER];
    w_ownWe    = we[REQ_LOADER];
    w_ownAddr  = addr[REQ_LOADER];
    w_ownWdata = wdata[REQ_LOADER];
    case (r_owner)
      2'(REQ_WB): begin
        w_ownReq   = req[REQ_WB];
        w_ownWe    = we[REQ_WB];
        w_ownAddr  = addr[REQ_WB];
        w_ownWdata = wdata[REQ_WB];
      end
      2'(REQ_READBACK): begin
        w_ownReq   = req[REQ_READBACK];
        w_ownWe    = we[REQ_READBACK];
        w_ownAddr  = addr[REQ_READBACK];
        w_ownWdata = wdata[REQ_READBACK];
      end
      default: ;
    endcase
  end

  assign w_own       = (r_state == OWN);
  assign w_beat      = w_own & w_ownReq;
  assign w_ownOneHot = oneHot(r_owner);

  assign gnt       = (w_own & ~reset) ? w_ownOneHot : '0;
  assign busy      = w_own & ~reset;
  assign mem_we    = w_beat & w_ownWe & ~reset;
  assign mem_addr  = w_ownAddr;
  assign mem_wdata = w_ownWdata;
  assign rvalid    = reset ? '0 : r_rvalid;
  assign rdata     = mem_rdata;

  // While owning, the pick looks only at the other requesters, starting just after the owner.
  assign w_pickLast    = w_own ? r_owner : r_last_owner;
  assign w_pickExclude = w_own ? w_ownOneHot : '0;
  assign w_handover    = w_own & (~w_ownReq | ((r_burst_cnt == LAST_BEAT) & w_pickValid));

  rr_pick u_rr_pick (
    .req        (req),
    .last_owner (w_pickLast),
    .exclude    (w_pickExclude),
    .valid      (w_pickValid),
    .winner     (w_pickWinner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= 2'(REQ_READBACK);
      r_burst_cnt  <= '0;
      r_rvalid     <= '0;
    end else begin
      r_rvalid <= (w_beat & ~w_ownWe) ? w_ownOneHot : '0;
      if (!w_own) begin
        if (w_pickValid) begin
          r_state     <= OWN;
          r_owner     <= w_pickWinner;
          r_burst_cnt <= '0;
        end
      end else if (w_handover) begin
        r_last_owner <= r_owner;
        r_burst_cnt  <= '0;
        if (w_pickValid) r_owner <= w_pickWinner;
        else             r_state <= IDLE;
      end else if (r_burst_cnt == LAST_BEAT) begin
        r_burst_cnt <= '0;
      end else begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 10, SRAM address width.
REQ-002 SHALL have parameter WORD_SIZE, default 16, SRAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive beats per grant while another requester waits.
REQ-004 SHALL have port clk, input, 1, sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, [2:0], request per requester; 0 = SPI loader, 1 = array writeback, 2 = SPI readback.
REQ-007 SHALL have port we, input, [2:0], per-requester write enable; 0 = read beat.
REQ-008 SHALL have port addr, input, [3][ADDR_SIZE], per-requester address.
REQ-009 SHALL have port wdata, input, [3][WORD_SIZE], per-requester write data.
REQ-010 SHALL have port gnt, output, [2:0], one-hot-or-zero current owner.
REQ-011 SHALL have port rvalid, output, [2:0], read data valid per requester.
REQ-012 SHALL have port rdata, output, WORD_SIZE, shared read data, equal to mem_rdata.
REQ-013 SHALL have ports mem_addr, mem_wdata and mem_we, outputs, ADDR_SIZE/WORD_SIZE/1, single-port SRAM drive.
REQ-014 SHALL have port mem_rdata, input, WORD_SIZE, SRAM read data, valid 1 cycle after a read address.
REQ-015 SHALL have port busy, output, 1, high while in OWN.

Function
REQ-016 SHALL implement states IDLE and OWN, with a registered owner index, a registered last_owner and a burst counter burst_cnt [$clog2(MAX_BURST)].
REQ-017 In IDLE, gnt SHALL be 0 and mem_we SHALL be 0; if any req is high, the FSM SHALL go to OWN with the round-robin winner next cycle and set burst_cnt=0 (request-to-grant latency exactly 1 cycle).
REQ-018 Round-robin SHALL search from last_owner+1 modulo 3 and pick the first requester with req high.
REQ-019 In OWN, gnt[owner] SHALL be 1, combinationally derived from registered state; mem_addr/mem_wdata SHALL equal the owner's addr/wdata, and mem_we SHALL equal we[owner] & req[owner].
REQ-020 A beat SHALL be a cycle in OWN with req[owner]=1; each beat SHALL increment burst_cnt.
REQ-021 If req[owner]=0 in OWN, the cycle SHALL not be a beat; the FSM SHALL hand over directly (no bubble) to the round-robin winner among the other requesters with burst_cnt=0, or go to IDLE if none; last_owner<=owner.
REQ-022 On a beat with burst_cnt==MAX_BURST-1 while another req is high, the FSM SHALL hand over as in REQ-021 next cycle.
REQ-023 On a beat with burst_cnt==MAX_BURST-1 and no other req, the owner SHALL keep the port and burst_cnt SHALL wrap to 0.
REQ-024 rvalid[i] SHALL be asserted exactly 1 cycle after a read beat (we=0) of requester i, and SHALL be 0 otherwise.
REQ-025 Changes to a non-owner's req, addr or we SHALL have no effect on the mem_* outputs.

Reset
REQ-026 While reset is high, gnt, rvalid, mem_we and busy SHALL be 0, overriding any beat in that cycle.
REQ-027 Next cycle after reset: state=IDLE, owner=0, last_owner=2 (requester 0 first), burst_cnt=0, rvalid=0; reset mid-burst SHALL abort without any further write.

Structure
REQ-028 Package arb_pkg SHALL hold the state enum (IDLE, OWN), NUM_REQ=3, and the requester indices REQ_LOADER=0, REQ_WB=1, REQ_READBACK=2.
REQ-029 The round-robin pick SHALL be one combinational sub-module, rr_pick (req, last_owner, exclude -> valid, winner).

Verification
REQ-030 Scenario: req=3'b001, we[0]=1 for 3 cycles, addr 0x00F..0x011 -> gnt[0] from cycle 1, three mem_we pulses at 0x00F, 0x010, 0x011, then IDLE.
REQ-031 Scenario: req[0] and req[1] held continuously, MAX_BURST=8 -> grants alternate 0,1,0 with exactly 8 beats each and no idle cycle between owners.
REQ-032 Scenario: requester 2 reads addr 0x020, SRAM holds 0xBEEF -> rvalid[2]=1 with rdata=0xBEEF exactly 1 cycle after the beat; rvalid[0] and rvalid[1] stay 0.
REQ-033 Scenario: req[1] alone for 20 beats -> continuous grant with burst_cnt wrapping, no gaps.
REQ-034 Scenario: reset asserted on the 3rd beat of a loader write burst -> no mem_we in the reset cycle, IDLE afterwards, first grant to requester 0 if all requesters request.
REQ-035 Scenario: owner drops req while req[2] is high -> gnt[2]=1 the very next cycle, and a pending write to a non-owner address never reaches mem_addr.
